fetch_pc_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the branch/jump resolution logic.
- Owns the architectural PC (word-addressed, sequential step +1) and issues one instruction-memory request at a time over a req/ready + rvalid handshake.
- Presents {pc, instr} to decode/branch resolution; applies next_pc/branch_taken redirects, which kill any in-flight fetch.

---
 rtl/fetch_pc_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_pc_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch stage owning the word-addressed PC.
// Issues one imem request at a time (req/ready, then rvalid), presents
// {pc, instr} downstream and applies redirects, killing in-flight fetches.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_kill_cnt.
module fetch_pc_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0000)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_kill_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_pend_pc;
  logic              r_pend_valid;
  logic              r_kill;
  logic              r_imem_req;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_instr;
  logic              r_instr_valid;

  // imem_addr is the fetch PC itself, which only moves while no request is up
  assign imem_req    = r_imem_req;
  assign imem_addr   = r_fetch_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;

  // Fetch FSM: request, wait for response, hold presented instruction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_fetch_pc    <= RESET_PC;
      r_pend_pc     <= RESET_PC;
      r_pend_valid  <= 1'b0;
      r_kill        <= 1'b0;
      r_imem_req    <= 1'b0;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (redirect_valid) r_fetch_pc <= redirect_pc;
          r_state    <= S_REQ;
          r_imem_req <= 1'b1;
        end
        S_REQ: begin
          // address stays put until accepted; a redirect here kills the response
          if (redirect_valid) begin
            r_pend_pc    <= redirect_pc;
            r_pend_valid <= 1'b1;
            r_kill       <= 1'b1;
          end
          if (imem_ready) begin
            r_state    <= S_WAIT;
            r_imem_req <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (redirect_valid) begin
              r_fetch_pc   <= redirect_pc;
              r_kill       <= 1'b0;
              r_pend_valid <= 1'b0;
              r_state      <= S_REQ;
              r_imem_req   <= 1'b1;
            end else if (r_kill) begin
              r_fetch_pc   <= r_pend_valid ? r_pend_pc : r_fetch_pc;
              r_kill       <= 1'b0;
              r_pend_valid <= 1'b0;
              r_state      <= S_REQ;
              r_imem_req   <= 1'b1;
            end else begin
              r_instr       <= imem_rdata;
              r_pc          <= r_fetch_pc;
              r_instr_valid <= 1'b1;
              r_state       <= S_HOLD;
            end
          end else if (redirect_valid) begin
            // last redirect wins while the response is still outstanding
            r_pend_pc    <= redirect_pc;
            r_pend_valid <= 1'b1;
            r_kill       <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            r_instr_valid <= 1'b0;
            r_fetch_pc    <= redirect_pc;
            r_state       <= S_REQ;
            r_imem_req    <= 1'b1;
          end else if (!stall) begin
            r_instr_valid <= 1'b0;
            r_fetch_pc    <= r_fetch_pc + ADDR_W'(1);
            r_state       <= S_REQ;
            r_imem_req    <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  localparam int unsigned CNT_W = 32;

  logic [CNT_W-1:0] r_perf_fetch_cnt;
  logic [CNT_W-1:0] r_perf_kill_cnt;
  logic             w_xfer;
  logic             w_drop;

  assign w_xfer = (r_state == S_HOLD) && !stall && !redirect_valid;
  assign w_drop = (r_state == S_WAIT) && imem_rvalid && (r_kill || redirect_valid);

  assign perf_fetch_cnt = r_perf_fetch_cnt;
  assign perf_kill_cnt  = r_perf_kill_cnt;

  // Count transferred instructions and discarded responses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_fetch_cnt <= '0;
      r_perf_kill_cnt  <= '0;
    end else begin
      if (w_xfer) r_perf_fetch_cnt <= r_perf_fetch_cnt + CNT_W'(1);
      if (w_drop) r_perf_kill_cnt  <= r_perf_kill_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a behavioural instruction memory
// returning word = addr + 32'hA000 after a programmable latency.
module tb_fetch_pc_unit;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_kill_cnt;
`endif

  int checks = 0;
  int errors = 0;

  int mem_lat    = 1;
  int ready_hold = 0;

  fetch_pc_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .pc             (pc),
    .instr          (instr),
    .instr_valid    (instr_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_kill_cnt  (perf_kill_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: ready after ready_hold cycles of a new request, rvalid mem_lat cycles after acceptance
  initial begin : memory
    int          lat_cnt;
    int          blk;
    logic        pend_acc;
    logic        prev_req;
    logic [31:0] acc_addr;
    logic [31:0] resp_addr;
    lat_cnt = 0; blk = 0; pend_acc = 1'b0; prev_req = 1'b0;
    acc_addr = '0; resp_addr = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk); #1;
      imem_rvalid = 1'b0;
      if (pend_acc) begin
        lat_cnt   = mem_lat;
        resp_addr = acc_addr;
      end
      if (lat_cnt > 0) begin
        lat_cnt = lat_cnt - 1;
        if (lat_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = resp_addr + 32'hA000;
        end
      end
      if (imem_req && !prev_req) blk = ready_hold;
      if (imem_req && blk == 0) begin
        imem_ready = 1'b1;
      end else begin
        imem_ready = 1'b0;
        if (imem_req && blk > 0) blk = blk - 1;
      end
      pend_acc = imem_req && imem_ready && rst_n;
      acc_addr = imem_addr;
      prev_req = imem_req;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset(input logic use_redir, input logic [31:0] rpc);
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; redirect_valid = use_redir; redirect_pc = rpc;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  // Returns just before the posedge at which the request is accepted
  task automatic wait_accept(output logic ok, output logic [31:0] a, output logic saw_v);
    ok = 1'b0; a = '0; saw_v = 1'b0;
    #2;
    for (int i = 0; i < TMO; i++) begin
      if (instr_valid === 1'b1) saw_v = 1'b1;
      if (imem_req === 1'b1 && imem_ready === 1'b1) begin
        ok = 1'b1; a = imem_addr;
        break;
      end
      @(negedge clk); #2;
    end
  endtask

  task automatic wait_valid(output logic ok, output logic [31:0] p, output logic [31:0] d);
    ok = 1'b0; p = '0; d = '0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (instr_valid === 1'b1) begin
        ok = 1'b1; p = pc; d = instr;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", pc); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 00000000", instr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
  endtask

  task automatic test_sequential();
    logic ok, sv;
    logic [31:0] a, p, d;
    do_reset(1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      wait_accept(ok, a, sv);
      checks++; if (ok !== 1'b1 || a !== 32'(k)) begin errors++; $display("FAIL seq_addr[%0d]: got ok=%b addr=%h expected addr=%h", k, ok, a, 32'(k)); end
      wait_valid(ok, p, d);
      checks++; if (ok !== 1'b1 || p !== 32'(k)) begin errors++; $display("FAIL seq_pc[%0d]: got ok=%b pc=%h expected %h", k, ok, p, 32'(k)); end
      checks++; if (d !== 32'hA000 + 32'(k)) begin errors++; $display("FAIL seq_instr[%0d]: got %h expected %h", k, d, 32'hA000 + 32'(k)); end
    end
  endtask

  task automatic test_stall();
    logic ok, sv;
    logic [31:0] a, p, d;
    do_reset(1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      wait_accept(ok, a, sv);
      wait_valid(ok, p, d);
    end
    checks++; if (ok !== 1'b1 || p !== 32'h2) begin errors++; $display("FAIL stall_first_pc: got ok=%b pc=%h expected 00000002", ok, p); end
    stall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || pc !== 32'h2 || instr !== 32'hA002 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got valid=%b pc=%h instr=%h req=%b expected 1/00000002/0000a002/0", c, instr_valid, pc, instr, imem_req);
      end
    end
    stall = 1'b0;
    wait_accept(ok, a, sv);
    checks++; if (ok !== 1'b1 || a !== 32'h3) begin errors++; $display("FAIL stall_next_addr: got ok=%b addr=%h expected 00000003", ok, a); end
    wait_valid(ok, p, d);
    checks++; if (p !== 32'h3 || d !== 32'hA003) begin errors++; $display("FAIL stall_next_pc: got pc=%h instr=%h expected 00000003/0000a003", p, d); end
  endtask

  task automatic test_redirect_wait();
    logic ok, sv;
    logic [31:0] a, p, d;
    mem_lat = 3;
    do_reset(1'b1, 32'h5);
    wait_accept(ok, a, sv);
    checks++; if (ok !== 1'b1 || a !== 32'h5) begin errors++; $display("FAIL rw_first_addr: got ok=%b addr=%h expected 00000005", ok, a); end
    @(posedge clk);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_accept(ok, a, sv);
    checks++; if (ok !== 1'b1 || a !== 32'h40) begin errors++; $display("FAIL rw_next_addr: got ok=%b addr=%h expected 00000040", ok, a); end
    checks++; if (sv !== 1'b0) begin errors++; $display("FAIL rw_killed_present: got instr_valid seen=%b expected 0", sv); end
    wait_valid(ok, p, d);
    checks++; if (p !== 32'h40 || d !== 32'hA040) begin errors++; $display("FAIL rw_pc: got pc=%h instr=%h expected 00000040/0000a040", p, d); end
    mem_lat = 1;
  endtask

  task automatic test_redirect_req();
    logic ok, sv;
    logic [31:0] a, p, d;
    ready_hold = 4;
    do_reset(1'b1, 32'h7);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h7) begin
        errors++;
        $display("FAIL rq_hold[%0d]: got req=%b addr=%h expected 1/00000007", c, imem_req, imem_addr);
      end
      redirect_valid = (c == 1);
      redirect_pc    = 32'h80;
    end
    redirect_valid = 1'b0;
    ready_hold = 0;
    wait_accept(ok, a, sv);
    checks++; if (ok !== 1'b1 || a !== 32'h7) begin errors++; $display("FAIL rq_accept_addr: got ok=%b addr=%h expected 00000007", ok, a); end
    @(posedge clk);
    wait_accept(ok, a, sv);
    checks++; if (ok !== 1'b1 || a !== 32'h80) begin errors++; $display("FAIL rq_next_addr: got ok=%b addr=%h expected 00000080", ok, a); end
    checks++; if (sv !== 1'b0) begin errors++; $display("FAIL rq_killed_present: got instr_valid seen=%b expected 0", sv); end
    wait_valid(ok, p, d);
    checks++; if (p !== 32'h80 || d !== 32'hA080) begin errors++; $display("FAIL rq_pc: got pc=%h instr=%h expected 00000080/0000a080", p, d); end
  endtask

  task automatic test_redirect_same_cycle();
    logic ok, sv;
    logic [31:0] a, p, d;
    do_reset(1'b1, 32'h9);
    wait_accept(ok, a, sv);
    checks++; if (ok !== 1'b1 || a !== 32'h9) begin errors++; $display("FAIL sc_first_addr: got ok=%b addr=%h expected 00000009", ok, a); end
    @(posedge clk);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      errors++;
      $display("FAIL sc_after: got valid=%b req=%b addr=%h expected 0/1/00000010", instr_valid, imem_req, imem_addr);
    end
    wait_valid(ok, p, d);
    checks++; if (p !== 32'h10 || d !== 32'hA010) begin errors++; $display("FAIL sc_pc: got pc=%h instr=%h expected 00000010/0000a010", p, d); end
  endtask

  task automatic test_wrap();
    logic ok, sv;
    logic [31:0] a, p, d;
    do_reset(1'b1, 32'hFFFF_FFFF);
    wait_accept(ok, a, sv);
    checks++; if (ok !== 1'b1 || a !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_first_addr: got ok=%b addr=%h expected ffffffff", ok, a); end
    wait_valid(ok, p, d);
    checks++; if (p !== 32'hFFFF_FFFF || d !== 32'h0000_9FFF) begin errors++; $display("FAIL wrap_first_pc: got pc=%h instr=%h expected ffffffff/00009fff", p, d); end
    wait_accept(ok, a, sv);
    checks++; if (ok !== 1'b1 || a !== 32'h0) begin errors++; $display("FAIL wrap_next_addr: got ok=%b addr=%h expected 00000000", ok, a); end
    wait_valid(ok, p, d);
    checks++; if (p !== 32'h0 || d !== 32'hA000) begin errors++; $display("FAIL wrap_next_pc: got pc=%h instr=%h expected 00000000/0000a000", p, d); end
  endtask

  task automatic test_reset_mid();
    logic ok, sv;
    logic [31:0] a, p, d;
    do_reset(1'b1, 32'h20);
    wait_accept(ok, a, sv);
    wait_valid(ok, p, d);
    checks++; if (p !== 32'h20 || d !== 32'hA020) begin errors++; $display("FAIL rm_pre_pc: got pc=%h instr=%h expected 00000020/0000a020", p, d); end
    mem_lat = 3;
    wait_accept(ok, a, sv);
    checks++; if (ok !== 1'b1 || a !== 32'h21) begin errors++; $display("FAIL rm_pre_addr: got ok=%b addr=%h expected 00000021", ok, a); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || pc !== 32'h0 || instr !== 32'h0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_reset_vals: got req=%b addr=%h pc=%h instr=%h valid=%b expected 0/00000000/00000000/00000000/0", imem_req, imem_addr, pc, instr, instr_valid);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_fetch_cnt !== 32'h0 || perf_kill_cnt !== 32'h0) begin
      errors++;
      $display("FAIL rm_perf: got fetch=%0d kill=%0d expected 0/0", perf_fetch_cnt, perf_kill_cnt);
    end
`endif
    rst_n = 1'b1;
    wait_accept(ok, a, sv);
    checks++; if (ok !== 1'b1 || a !== 32'h0) begin errors++; $display("FAIL rm_first_addr: got ok=%b addr=%h expected 00000000", ok, a); end
    wait_valid(ok, p, d);
    checks++; if (p !== 32'h0 || d !== 32'hA000) begin errors++; $display("FAIL rm_first_pc: got pc=%h instr=%h expected 00000000/0000a000", p, d); end
    mem_lat = 1;
  endtask

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_req();
    test_redirect_same_cycle();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
